// File: rtl/mem_acc_pkg.sv
// Shared encodings for the memory accumulator: controller states and reduction op codes.
// No logic here; latency/backpressure are properties of the blocks that import it.
package mem_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ACC   = 2'd2,
        FIN   = 2'd3
    } state_t;

    localparam logic OP_SUM = 1'b0;
    localparam logic OP_MAX = 1'b1;

endpackage

// File: rtl/acc_mem.sv
// DEPTH x DATA_W RAM, synchronous write, registered read (1-cycle latency), no backpressure.
// A write and a read of the same address on one edge return the new data.
module acc_mem #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_dat,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_dat
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are deliberately not reset; data survives an aborted operation.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
        if (wr_en && (wr_addr == rd_addr)) begin
            rd_dat <= wr_dat;
        end else begin
            rd_dat <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/mem_accumulator_param.sv
// Loadable RAM plus start/busy/done controller reducing a wrapping window (sum/sat-sum/max).
// Latency: done n+1 cycles after the start edge; start and writes are ignored while busy.
module mem_accumulator_param
    import mem_acc_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int ACC_W  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    input  logic              op_sel,
    input  logic              sat_en,
    output logic              busy,
    output logic              done,
    output logic [ACC_W-1:0]  result,
    output logic              overflow
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_L   = (ADDR_W + 1)'(1);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q;
    logic [ADDR_W:0]    cnt_q;
    logic               op_q;
    logic               sat_q;
    logic [ACC_W-1:0]   acc_q;
    logic               ovf_q;
    logic [ACC_W-1:0]   result_q;
    logic               overflow_q;
    logic               done_q;

    logic [ADDR_W:0]    n_eff;
    logic [ADDR_W-1:0]  rd_addr;
    logic [DATA_W-1:0]  rd_dat;
    logic               mem_we;
    logic [ACC_W-1:0]   operand;
    logic [ACC_W:0]     sum_ext;
    logic [ACC_W-1:0]   comb_acc;
    logic               comb_ovf;
    logic               start_ok;

    assign n_eff    = (len > DEPTH_L) ? DEPTH_L : len;
    assign start_ok = (state_q == IDLE) && start;
    assign mem_we   = (state_q == IDLE) && wr_en;

    acc_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (mem_we),
        .wr_addr (wr_addr),
        .wr_dat  (data_in),
        .rd_addr (rd_addr),
        .rd_dat  (rd_dat)
    );

    // Combine the word returned by the RAM this cycle into the running value.
    assign operand = ACC_W'(rd_dat);
    assign sum_ext = {1'b0, acc_q} + {1'b0, operand};

    always_comb begin
        comb_acc = acc_q;
        comb_ovf = ovf_q;
        if (op_q == OP_MAX) begin
            comb_acc = (operand > acc_q) ? operand : acc_q;
        end else begin
            comb_ovf = ovf_q | sum_ext[ACC_W];
            comb_acc = (sum_ext[ACC_W] && sat_q) ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
        end
    end

    // n==1 skips FETCH: the single word arrives while in ACC.
    always_comb begin
        state_d = state_q;
        rd_addr = addr_q;
        unique case (state_q)
            IDLE: begin
                rd_addr = base_addr;
                if (start) begin
                    if (n_eff == '0) begin
                        state_d = FIN;
                    end else if (n_eff == ONE_L) begin
                        state_d = ACC;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                if (cnt_q == ONE_L) begin
                    state_d = ACC;
                end
            end
            ACC:     state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            op_q       <= OP_SUM;
            sat_q      <= 1'b0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == FIN);
            if (start_ok) begin
                addr_q     <= base_addr + ADDR_W'(1);
                cnt_q      <= (n_eff == '0) ? '0 : n_eff - ONE_L;
                op_q       <= op_sel;
                sat_q      <= sat_en;
                acc_q      <= '0;
                ovf_q      <= 1'b0;
                overflow_q <= 1'b0;
            end
            if (state_q == FETCH) begin
                addr_q <= addr_q + ADDR_W'(1);
                cnt_q  <= cnt_q - ONE_L;
                acc_q  <= comb_acc;
                ovf_q  <= comb_ovf;
            end
            if (state_q == ACC) begin
                acc_q <= comb_acc;
                ovf_q <= comb_ovf;
            end
            if (state_q == FIN) begin
                result_q   <= acc_q;
                overflow_q <= ovf_q;
            end
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign result   = result_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_mem_accumulator_param.sv
// Directed bench: a 12-bit accumulator instance and an 8-bit one for saturation/max cases.
// Inputs are shared; sel routes start/wr_en to one instance and muxes its outputs back.
module tb_mem_accumulator_param;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sel = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [7:0]  data_in = '0;
    logic        start = 1'b0;
    logic [3:0]  base_addr = '0;
    logic [4:0]  len = '0;
    logic        op_sel = 1'b0;
    logic        sat_en = 1'b0;

    logic        busy_a, done_a, ovf_a;
    logic [11:0] result_a;
    logic        busy_b, done_b, ovf_b;
    logic [7:0]  result_b;

    logic        busy_m, done_m, ovf_m;
    logic [11:0] result_m;

    int n_tests = 0;
    int n_fail  = 0;
    int r_cycles, r_busy;
    logic r_done2, r_ovf;
    logic [11:0] r_res;

    always #5 clk = ~clk;

    mem_accumulator_param #(.DATA_W(8), .ADDR_W(4), .ACC_W(12)) u_dut_a (
        .clk(clk), .rst(rst), .wr_en(wr_en & ~sel), .wr_addr(wr_addr), .data_in(data_in),
        .start(start & ~sel), .base_addr(base_addr), .len(len), .op_sel(op_sel), .sat_en(sat_en),
        .busy(busy_a), .done(done_a), .result(result_a), .overflow(ovf_a)
    );

    mem_accumulator_param #(.DATA_W(8), .ADDR_W(4), .ACC_W(8)) u_dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en & sel), .wr_addr(wr_addr), .data_in(data_in),
        .start(start & sel), .base_addr(base_addr), .len(len), .op_sel(op_sel), .sat_en(sat_en),
        .busy(busy_b), .done(done_b), .result(result_b), .overflow(ovf_b)
    );

    assign busy_m   = sel ? busy_b : busy_a;
    assign done_m   = sel ? done_b : done_a;
    assign ovf_m    = sel ? ovf_b : ovf_a;
    assign result_m = sel ? {4'h0, result_b} : result_a;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_addr = a;
        data_in = d;
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // Start at edge T0; r_cycles counts edges after T0 until done is seen.
    // poke > 0 drives start+wr_en (addr 5, 0xAA) for one cycle mid-run.
    task automatic run(input logic [3:0] b, input logic [4:0] l, input logic op,
                       input logic sat, input int poke);
        @(negedge clk);
        base_addr = b;
        len       = l;
        op_sel    = op;
        sat_en    = sat;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        r_cycles = 0;
        r_busy   = 0;
        while (!done_m && r_cycles < 100) begin
            if (busy_m) r_busy++;
            @(posedge clk);
            #1;
            r_cycles++;
            if (r_cycles == poke) begin
                start = 1'b1; wr_en = 1'b1; wr_addr = 4'd5; data_in = 8'hAA;
                base_addr = 4'd3; len = 5'd1;
            end else begin
                start = 1'b0; wr_en = 1'b0;
            end
        end
        chk("done_seen", {31'd0, done_m}, 32'd1);
        r_res = result_m;
        r_ovf = ovf_m;
        @(posedge clk);
        #1;
        r_done2 = done_m;
    endtask

    initial begin
        #3;
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_done", {31'd0, done_a}, 32'd0);
        chk("rst_result", {20'd0, result_a}, 32'd0);
        chk("rst_ovf", {31'd0, ovf_a}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 16; i++) wr(4'(i), 8'(i + 1));

        run(4'd0, 5'd16, 1'b0, 1'b0, 0);
        chk("t1_cycles", 32'(r_cycles), 32'd17);
        chk("t1_busy", 32'(r_busy), 32'd17);
        chk("t1_result", {20'd0, r_res}, 32'd136);
        chk("t1_ovf", {31'd0, r_ovf}, 32'd0);
        chk("t1_done_pulse", {31'd0, r_done2}, 32'd0);

        run(4'd14, 5'd4, 1'b0, 1'b0, 0);
        chk("t2_wrap_result", {20'd0, r_res}, 32'd34);
        chk("t2_cycles", 32'(r_cycles), 32'd5);

        run(4'd0, 5'd16, 1'b0, 1'b1, 0);
        chk("sat_no_ovf_result", {20'd0, r_res}, 32'd136);
        chk("sat_no_ovf_flag", {31'd0, r_ovf}, 32'd0);

        run(4'd0, 5'd31, 1'b0, 1'b0, 0);
        chk("clamp_result", {20'd0, r_res}, 32'd136);
        chk("clamp_cycles", 32'(r_cycles), 32'd17);

        run(4'd0, 5'd16, 1'b0, 1'b0, 3);
        chk("t5_cycles", 32'(r_cycles), 32'd17);
        chk("t5_result", {20'd0, r_res}, 32'd136);
        chk("t5_single_done", {31'd0, r_done2}, 32'd0);
        run(4'd5, 5'd1, 1'b0, 1'b0, 0);
        chk("t5_mem5", {20'd0, r_res}, 32'd6);
        chk("t5_n1_cycles", 32'(r_cycles), 32'd2);

        @(negedge clk);
        base_addr = 4'd0; len = 5'd16; op_sel = 1'b0; sat_en = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("t6_busy", {31'd0, busy_a}, 32'd0);
        chk("t6_done", {31'd0, done_a}, 32'd0);
        chk("t6_result", {20'd0, result_a}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run(4'd0, 5'd2, 1'b0, 1'b0, 0);
        chk("t6_rerun", {20'd0, r_res}, 32'd3);

        sel = 1'b1;
        for (int i = 0; i < 16; i++) wr(4'(i), 8'hFF);
        run(4'd0, 5'd16, 1'b0, 1'b1, 0);
        chk("t3_sat_result", {20'd0, r_res}, 32'd255);
        chk("t3_sat_ovf", {31'd0, r_ovf}, 32'd1);
        run(4'd0, 5'd16, 1'b0, 1'b0, 0);
        chk("t3_wrap_result", {20'd0, r_res}, 32'd240);
        chk("t3_wrap_ovf", {31'd0, r_ovf}, 32'd1);

        wr(4'd0, 8'd3);
        wr(4'd1, 8'd200);
        wr(4'd2, 8'd7);
        wr(4'd3, 8'd200);
        wr(4'd4, 8'd9);
        run(4'd0, 5'd5, 1'b1, 1'b0, 0);
        chk("t4_max_result", {20'd0, r_res}, 32'd200);
        chk("t4_max_ovf", {31'd0, r_ovf}, 32'd0);
        run(4'd0, 5'd0, 1'b1, 1'b0, 0);
        chk("t4_len0_cycles", 32'(r_cycles), 32'd1);
        chk("t4_len0_result", {20'd0, r_res}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
